// File: rtl/jtag_axi_txn_ctrl_pkg.sv
// Shared types and helpers for the JTAG-to-AXI4-Lite transaction sequencer.
package jtag_axi_txn_ctrl_pkg;

    typedef logic [2:0] axi_txn_st_t;
    localparam axi_txn_st_t IDLE    = 3'd0;
    localparam axi_txn_st_t WR      = 3'd1;
    localparam axi_txn_st_t WR_RESP = 3'd2;
    localparam axi_txn_st_t RD      = 3'd3;
    localparam axi_txn_st_t RD_DATA = 3'd4;
    localparam axi_txn_st_t DONE    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_OK        = 3'd1,
        ST_SLVERR    = 3'd2,
        ST_DECERR    = 3'd3,
        ST_ALIGN_ERR = 3'd4,
        ST_TIMEOUT   = 3'd5
    } txn_status_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } txn_size_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    function automatic txn_status_t resp_to_status(input logic [1:0] resp);
        case (resp)
            AXI_RESP_OKAY, AXI_RESP_EXOKAY: return ST_OK;
            AXI_RESP_SLVERR:                return ST_SLVERR;
            default:                        return ST_DECERR;
        endcase
    endfunction

    // Size code 3 is reserved and always rejected.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] size_strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/jtag_sync_ff.sv
// Multi-flop single-bit synchroniser with asynchronous active-low reset.
module jtag_sync_ff #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_axi_txn_ctrl.sv
// Runs one AXI4-Lite read or write per req_tgl edge from the TCK side and
// returns status, read data and an ack toggle.
module jtag_axi_txn_ctrl
    import jtag_axi_txn_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                  aclk,
    input  logic                  trstn,
    input  logic                  req_tgl,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    output logic                  ack_tgl,
    output logic [31:0]           rsp_rdata,
    output logic [2:0]            rsp_status,
    output logic                  busy,
    output logic                  overrun,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [31:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    axi_txn_st_t           r_state;
    logic                  r_req_prev;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_ack;
    logic                  r_busy;
    logic                  r_overrun;
    logic [31:0]           r_rdata;
    txn_status_t           r_rsp_status;
    txn_status_t           r_pend_status;
    logic                  r_timed_out;
    logic [TMO_W-1:0]      r_tmo_cnt;

    logic w_req_sync;
    logic w_req_pulse;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_waiting;
    logic w_progress;
    logic w_tmo_fire;

    jtag_sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .i_clk (aclk),
        .i_rstn(trstn),
        .i_d   (req_tgl),
        .o_q   (w_req_sync)
    );

    assign w_req_pulse = w_req_sync ^ r_req_prev;
    assign w_aw_hs     = r_awvalid & m_awready;
    assign w_w_hs      = r_wvalid & m_wready;
    assign w_aw_done   = ~r_awvalid | m_awready;
    assign w_w_done    = ~r_wvalid | m_wready;

    always_comb begin
        w_waiting  = 1'b0;
        w_progress = 1'b0;
        case (r_state)
            WR: begin
                w_waiting  = 1'b1;
                w_progress = w_aw_hs | w_w_hs;
            end
            WR_RESP: begin
                w_waiting  = 1'b1;
                w_progress = m_bvalid;
            end
            RD: begin
                w_waiting  = 1'b1;
                w_progress = m_arready;
            end
            RD_DATA: begin
                w_waiting  = 1'b1;
                w_progress = m_rvalid;
            end
            default: begin
                w_waiting  = 1'b0;
                w_progress = 1'b0;
            end
        endcase
        w_tmo_fire = TMO_EN && w_waiting && !w_progress && !r_timed_out
                     && (r_tmo_cnt == TMO_LAST);
    end

    always_ff @(posedge aclk or negedge trstn) begin
        if (!trstn) begin
            r_state       <= IDLE;
            r_req_prev    <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_ack         <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_rdata       <= '0;
            r_rsp_status  <= ST_IDLE;
            r_pend_status <= ST_IDLE;
            r_timed_out   <= 1'b0;
            r_tmo_cnt     <= '0;
        end else begin
            r_req_prev <= w_req_sync;

            // A timeout acks early; the bus side keeps draining with ack/status frozen.
            if (w_tmo_fire) begin
                r_timed_out  <= 1'b1;
                r_rsp_status <= ST_TIMEOUT;
                r_ack        <= ~r_ack;
            end

            if (!w_waiting || w_progress) begin
                r_tmo_cnt <= '0;
            end else if (!r_timed_out) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if (w_req_pulse && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_req_pulse) begin
                        r_overrun   <= 1'b0;
                        r_busy      <= 1'b1;
                        r_timed_out <= 1'b0;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_wstrb     <= size_strobe(req_size, req_addr[1:0]);
                        if (size_misaligned(req_size, req_addr[1:0])) begin
                            r_pend_status <= ST_ALIGN_ERR;
                            r_state       <= DONE;
                        end else if (req_wr) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RD;
                        end
                    end
                end
                WR: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_bvalid) begin
                        r_bready      <= 1'b0;
                        r_pend_status <= resp_to_status(m_bresp);
                        r_state       <= DONE;
                    end
                end
                RD: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_rvalid) begin
                        r_rready      <= 1'b0;
                        r_pend_status <= resp_to_status(m_rresp);
                        if (!r_timed_out) r_rdata <= m_rdata;
                        r_state       <= DONE;
                    end
                end
                DONE: begin
                    if (!r_timed_out) begin
                        r_rsp_status <= r_pend_status;
                        r_ack        <= ~r_ack;
                    end
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack_tgl    = r_ack;
    assign rsp_rdata  = r_rdata;
    assign rsp_status = r_rsp_status;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign m_awaddr   = r_addr;
    assign m_awprot   = AXI_PROT_DEFAULT;
    assign m_awvalid  = r_awvalid;
    assign m_wdata    = r_wdata;
    assign m_wstrb    = r_wstrb;
    assign m_wvalid   = r_wvalid;
    assign m_bready   = r_bready;
    assign m_araddr   = r_addr;
    assign m_arprot   = AXI_PROT_DEFAULT;
    assign m_arvalid  = r_arvalid;
    assign m_rready   = r_rready;

endmodule

// File: tb/tb_jtag_axi_txn_ctrl.sv
// Directed plus randomized bench for jtag_axi_txn_ctrl with a delay-programmable AXI slave.
module tb_jtag_axi_txn_ctrl;
    import jtag_axi_txn_ctrl_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned TMO = 16;

    logic          aclk = 1'b0;
    logic          trstn = 1'b0;
    logic          req_tgl = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          req_wr = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          ack_tgl;
    logic [31:0]   rsp_rdata;
    logic [2:0]    rsp_status;
    logic          busy;
    logic          overrun;
    logic [AW-1:0] m_awaddr;
    logic [2:0]    m_awprot;
    logic          m_awvalid;
    logic          m_awready = 1'b0;
    logic [31:0]   m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_wvalid;
    logic          m_wready = 1'b0;
    logic [1:0]    m_bresp = 2'b00;
    logic          m_bvalid = 1'b0;
    logic          m_bready;
    logic [AW-1:0] m_araddr;
    logic [2:0]    m_arprot;
    logic          m_arvalid;
    logic          m_arready = 1'b0;
    logic [31:0]   m_rdata = '0;
    logic [1:0]    m_rresp = 2'b00;
    logic          m_rvalid = 1'b0;
    logic          m_rready;

    always #5 aclk = ~aclk;

    jtag_axi_txn_ctrl #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (2)
    ) dut (
        .aclk(aclk), .trstn(trstn), .req_tgl(req_tgl), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wr(req_wr), .req_size(req_size),
        .ack_tgl(ack_tgl), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .busy(busy), .overrun(overrun),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;

    int unsigned aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, ack_edges = 0;
    logic        saw_valid = 1'b0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;

    logic [31:0] exp_rdata = '0;

    // Slave responder and monitor; a handshake is counted at the negedge where ready meets valid.
    initial begin : slave
        int unsigned aw_c, w_c, b_c, ar_c, r_c;
        logic ack_prev;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; ack_prev = 1'b0;
        forever begin
            @(negedge aclk);
            if (!trstn) begin
                m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
                m_arready = 1'b0; m_rvalid = 1'b0;
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
                ack_prev = 1'b0;
            end else begin
                if (m_awvalid) begin
                    m_awready = (aw_c >= cfg_aw_dly);
                    aw_c++;
                    if (m_awready) begin aw_hs++; cap_awaddr = m_awaddr; end
                end else begin m_awready = 1'b0; aw_c = 0; end
                if (m_wvalid) begin
                    m_wready = (w_c >= cfg_w_dly);
                    w_c++;
                    if (m_wready) begin w_hs++; cap_wdata = m_wdata; cap_wstrb = m_wstrb; end
                end else begin m_wready = 1'b0; w_c = 0; end
                if (m_bready) begin
                    if (b_c >= cfg_b_dly) begin m_bvalid = 1'b1; m_bresp = cfg_bresp; b_hs++; end
                    b_c++;
                end else begin m_bvalid = 1'b0; b_c = 0; end
                if (m_arvalid) begin
                    m_arready = (ar_c >= cfg_ar_dly);
                    ar_c++;
                    if (m_arready) begin ar_hs++; cap_araddr = m_araddr; end
                end else begin m_arready = 1'b0; ar_c = 0; end
                if (m_rready) begin
                    if (r_c >= cfg_r_dly) begin
                        m_rvalid = 1'b1; m_rdata = cfg_rdata; m_rresp = cfg_rresp; r_hs++;
                    end
                    r_c++;
                end else begin m_rvalid = 1'b0; r_c = 0; end
                if (m_awvalid || m_wvalid || m_arvalid) saw_valid = 1'b1;
                if (ack_tgl !== ack_prev) ack_edges++;
                ack_prev = ack_tgl;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; ack_edges = 0;
        saw_valid = 1'b0;
    endtask

    // Reference rules: access of 2^size bytes must be naturally aligned, size 3 rejected.
    function automatic logic [2:0] model_status(input logic [1:0] size, input logic [31:0] addr,
                                                input logic [1:0] resp);
        int unsigned nbytes;
        if (size == 2'd3) return ST_ALIGN_ERR;
        nbytes = 1 << size;
        if ((addr % nbytes) != 0) return ST_ALIGN_ERR;
        if (resp == 2'b10) return ST_SLVERR;
        if (resp == 2'b11) return ST_DECERR;
        return ST_OK;
    endfunction

    function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
        int unsigned nbytes;
        nbytes = 1 << size;
        return 4'(((1 << nbytes) - 1) << (addr % 4));
    endfunction

    task automatic send_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
        req_wr = wr; req_size = size; req_addr = addr; req_wdata = wdata;
        req_tgl = ~req_tgl;
    endtask

    task automatic wait_ack(input logic ack0, input int unsigned bound, output logic got);
        got = 1'b0;
        for (int unsigned i = 0; i < bound; i++) begin
            @(negedge aclk);
            if (ack_tgl !== ack0) begin got = 1'b1; break; end
        end
    endtask

    task automatic do_txn(input string tag, input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [1:0] resp,
                          input int unsigned awd, input int unsigned wd, input int unsigned bd,
                          input int unsigned ard, input int unsigned rd);
        logic        ack0, got;
        logic [2:0]  exp_st;
        clear_mon();
        cfg_aw_dly = awd; cfg_w_dly = wd; cfg_b_dly = bd; cfg_ar_dly = ard; cfg_r_dly = rd;
        cfg_bresp = resp; cfg_rresp = resp; cfg_rdata = rdata;
        exp_st = model_status(size, addr, resp);
        ack0 = ack_tgl;
        send_req(wr, size, addr, wdata);
        wait_ack(ack0, 300, got);
        check({tag, ".ack_seen"}, got, 1);
        check({tag, ".busy_at_ack"}, busy, 0);
        repeat (4) @(negedge aclk);
        check({tag, ".ack_once"}, ack_edges, 1);
        check({tag, ".status"}, rsp_status, exp_st);
        check({tag, ".overrun"}, overrun, 0);
        if (exp_st == ST_ALIGN_ERR) begin
            check({tag, ".no_valid"}, saw_valid, 0);
        end else if (wr) begin
            check({tag, ".aw_hs"}, aw_hs, 1);
            check({tag, ".w_hs"}, w_hs, 1);
            check({tag, ".b_hs"}, b_hs, 1);
            check({tag, ".awaddr"}, cap_awaddr, addr);
            check({tag, ".wdata"}, cap_wdata, wdata);
            check({tag, ".wstrb"}, cap_wstrb, model_strb(size, addr));
        end else begin
            check({tag, ".ar_hs"}, ar_hs, 1);
            check({tag, ".r_hs"}, r_hs, 1);
            check({tag, ".araddr"}, cap_araddr, addr);
            exp_rdata = rdata;
        end
        check({tag, ".rdata"}, rsp_rdata, exp_rdata);
    endtask

    initial begin : main
        logic        ack0, got;
        int unsigned n;
        logic [1:0]  sz;
        logic [31:0] ad;

        repeat (3) @(negedge aclk);
        check("rst.ack", ack_tgl, 0);
        check("rst.busy", busy, 0);
        check("rst.overrun", overrun, 0);
        check("rst.rdata", rsp_rdata, 0);
        check("rst.status", rsp_status, ST_IDLE);
        check("rst.valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        trstn = 1'b1;
        repeat (3) @(negedge aclk);

        do_txn("wr_word", 1'b1, 2'd2, 32'h1000_0004, 32'hDEAD_BEEF, '0, 2'b00, 3, 0, 1, 0, 0);
        check("wr_word.prot", m_awprot, 0);
        do_txn("rd_byte", 1'b0, 2'd0, 32'h2000_0003, '0, 32'h1234_5678, 2'b10, 0, 0, 0, 1, 2);
        do_txn("wr_byte2", 1'b1, 2'd0, 32'h6000_0002, 32'h00AB_0000, '0, 2'b00, 0, 2, 0, 0, 0);
        do_txn("wr_both_rdy", 1'b1, 2'd1, 32'h6000_0002, 32'h1111_2222, '0, 2'b11, 0, 0, 0, 0, 0);
        do_txn("half_misal", 1'b1, 2'd1, 32'h0000_0001, 32'h5555_5555, '0, 2'b00, 0, 0, 0, 0, 0);
        do_txn("size3", 1'b0, 2'd3, 32'h0000_0000, '0, 32'hFFFF_0000, 2'b00, 0, 0, 0, 0, 0);

        // Second request edge while the first is still in flight.
        clear_mon();
        cfg_aw_dly = 6; cfg_w_dly = 1; cfg_b_dly = 1; cfg_bresp = 2'b00;
        ack0 = ack_tgl;
        send_req(1'b1, 2'd2, 32'h4000_0010, 32'hCAFE_F00D);
        repeat (2) @(negedge aclk);
        req_tgl = ~req_tgl;
        wait_ack(ack0, 100, got);
        check("ovr.ack_seen", got, 1);
        repeat (10) @(negedge aclk);
        check("ovr.overrun", overrun, 1);
        check("ovr.ack_once", ack_edges, 1);
        check("ovr.status", rsp_status, ST_OK);
        check("ovr.aw_hs", aw_hs, 1);
        do_txn("ovr_clear", 1'b0, 2'd2, 32'h4000_0020, '0, 32'h0BAD_F00D, 2'b01, 0, 0, 0, 0, 0);

        // AR stalls well past the timeout.
        clear_mon();
        cfg_ar_dly = 40; cfg_r_dly = 2; cfg_rresp = 2'b00; cfg_rdata = 32'h7777_8888;
        ack0 = ack_tgl;
        send_req(1'b0, 2'd2, 32'h3000_0000, '0);
        n = 0; got = 1'b0;
        for (int unsigned i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (ack_tgl !== ack0) begin got = 1'b1; break; end
            if (m_arvalid) n++;
        end
        check("tmo.ack_seen", got, 1);
        check("tmo.cycles", n, TMO);
        check("tmo.arvalid_held", m_arvalid, 1);
        check("tmo.status", rsp_status, ST_TIMEOUT);
        check("tmo.busy_held", busy, 1);
        got = 1'b0;
        for (int unsigned i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (!busy) begin got = 1'b1; break; end
        end
        check("tmo.drained", got, 1);
        repeat (4) @(negedge aclk);
        check("tmo.ack_once", ack_edges, 1);
        check("tmo.status_kept", rsp_status, ST_TIMEOUT);
        check("tmo.rdata_kept", rsp_rdata, exp_rdata);
        check("tmo.ar_hs", ar_hs, 1);
        check("tmo.r_hs", r_hs, 1);

        // Asynchronous reset while waiting for the write response.
        clear_mon();
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 12; cfg_ar_dly = 0; cfg_r_dly = 0;
        send_req(1'b1, 2'd2, 32'h5000_0000, 32'h0123_4567);
        got = 1'b0;
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (m_bready) begin got = 1'b1; break; end
        end
        check("arst.reached_wresp", got, 1);
        @(negedge aclk);
        #2;
        trstn = 1'b0;
        req_tgl = 1'b0;
        #1;
        check("arst.valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        check("arst.ack", ack_tgl, 0);
        check("arst.busy", busy, 0);
        check("arst.status", rsp_status, ST_IDLE);
        exp_rdata = '0;
        repeat (3) @(negedge aclk);
        trstn = 1'b1;
        repeat (3) @(negedge aclk);
        do_txn("arst_read", 1'b0, 2'd2, 32'h5000_0008, '0, 32'h9ABC_DEF0, 2'b00, 0, 0, 0, 2, 1);

        for (int unsigned t = 0; t < 24; t++) begin
            sz = 2'($urandom_range(0, 3));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            do_txn("rand", 1'($urandom_range(0, 1)), sz, ad, $urandom, $urandom,
                   2'($urandom_range(0, 3)), $urandom_range(0, 8), $urandom_range(0, 8),
                   $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jtag_axi_txn_ctrl.md
Name: jtag_axi_txn_ctrl

Overview:
Sequences single AXI4-Lite transactions on behalf of the JTAG DR chain. The TCK-domain register file latches address, write data and control, then toggles a request line. This block synchronises the request into the aclk domain, checks alignment, drives one AXI4-Lite read or write, and returns read data, status and an acknowledge toggle to the JTAG side.

Parameters:
ADDR_WIDTH, 32, AXI address width
TIMEOUT_CYCLES, 4096, aclk cycles waited on any AXI channel before status TIMEOUT; 0 disables
SYNC_STAGES, 2, flop stages on the req_tgl synchroniser (>=2)

Ports:
aclk  in  1  AXI clock; all flops in this domain
trstn  in  1  reset, asynchronous, active-low; resets all state in this block
req_tgl  in  1  TCK-domain toggle; each edge is one transaction request
req_addr  in  ADDR_WIDTH  quasi-static address; stable from req_tgl edge until ack_tgl edge
req_wdata  in  32  quasi-static write data
req_wr  in  1  quasi-static; 1=write, 0=read
req_size  in  2  quasi-static; 0=byte, 1=half, 2=word, 3=reserved
ack_tgl  out  1  toggles once per completed or rejected request
rsp_rdata  out  32  read data of last read; holds value otherwise
rsp_status  out  3  txn_status_t of last request
busy  out  1  transaction in flight
overrun  out  1  sticky; request edge arrived while busy
m_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  AW channel
m_awready  in  1
m_wdata/wstrb/wvalid  out  32/4/1  W channel
m_wready  in  1
m_bresp/bvalid  in  2/1;  m_bready  out  1
m_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  AR channel
m_arready  in  1
m_rdata/rresp/rvalid  in  32/2/1;  m_rready  out  1

Behaviour:
- Reset: state IDLE; all valids/readys 0; ack_tgl 0, busy 0, overrun 0, rsp_rdata 0, rsp_status ST_IDLE; synchroniser and edge-detect flops 0.
- Request detect: req_tgl passes SYNC_STAGES flops, then an edge detector (XOR with previous synced value); one pulse per edge. Quasi-static inputs are sampled on that pulse, with no synchroniser.
- IDLE + pulse: size 3, or misalignment (size1 with addr[0]=1, size2 with addr[1:0]!=0) -> DONE with ST_ALIGN_ERR and no AXI activity. Else write -> WR; read -> RD. busy=1 from the cycle after the pulse.
- Pulse while busy: request dropped, overrun set; no ack for it. overrun clears on the next accepted pulse in IDLE.
- WR: awvalid and wvalid asserted the same cycle. Each drops independently after its handshake. After both handshakes -> WR_RESP.
- wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'hF. wdata is driven unshifted; the JTAG side pre-positions lanes. awprot/arprot = 3'b000.
- WR_RESP: bready=1; on bvalid -> DONE, status from bresp (OKAY->ST_OK, SLVERR->ST_SLVERR, DECERR->ST_DECERR, EXOKAY->ST_OK).
- RD: arvalid until arready -> RD_DATA. RD_DATA: rready=1; on rvalid capture rdata into rsp_rdata, map rresp as for bresp -> DONE.
- DONE: one cycle; updates rsp_status and toggles ack_tgl; busy=0 the next cycle -> IDLE. A pulse arriving in DONE counts as busy (overrun).
- Timeout: a counter resets on entry to WR/RD/WR_RESP/RD_DATA and increments each cycle without a handshake. On reaching TIMEOUT_CYCLES: rsp_status=ST_TIMEOUT and ack_tgl toggles immediately.
  - Valids stay asserted, per AXI. The FSM keeps draining to completion, then returns to IDLE without a second ack.
  - rsp_status and rsp_rdata are not overwritten by the late response.
  - busy stays 1 until drained.
- Simultaneous awready and wready in the first cycle: both complete, and WR_RESP is entered next cycle.
- Reset mid-transaction: immediate abandon. Bus-side protocol violation on assertion of trstn is accepted by design.

Decomposition:
- jtag_pkg additions:
  - axi_txn_st_t {IDLE, WR, WR_RESP, RD, RD_DATA, DONE}
  - txn_status_t {ST_IDLE, ST_OK, ST_SLVERR, ST_DECERR, ST_ALIGN_ERR, ST_TIMEOUT}
  - txn_size_t {SZ_BYTE, SZ_HALF, SZ_WORD}
  - AXI resp constants
- Sub-module: jtag_sync_ff (parameterised SYNC_STAGES bit synchroniser, async active-low reset), reused for ack_tgl on the TCK side.

Test Plan:
- Word write addr 0x1000_0004, wdata 0xDEADBEEF; awready delayed 3 cycles, wready immediate, bresp OKAY -> wstrb 4'hF, single AW and W handshake, ack_tgl toggles once, rsp_status ST_OK, busy low after DONE.
- Byte read addr 0x2000_0003; rdata 0x1234_5678, rresp SLVERR -> araddr 0x2000_0003, rsp_rdata 0x12345678, rsp_status ST_SLVERR; write size byte at addr[1:0]=2 -> wstrb 4'b0100.
- Half write addr 0x0000_0001 -> no AW/W/AR valid ever asserted, rsp_status ST_ALIGN_ERR, one ack toggle; same with size 3.
- Second req_tgl edge 2 cycles after the first while busy -> overrun=1, exactly one ack; next request in IDLE clears overrun.
- TIMEOUT_CYCLES=16, arready held 0 for 40 cycles -> ack at cycle 16 with ST_TIMEOUT, arvalid stays high; arready then rvalid -> no second ack, status stays ST_TIMEOUT, busy falls.
- trstn asserted during WR_RESP -> all valids/readys 0 and ack_tgl 0 asynchronously; after release a read completes normally with ST_OK.
